// File: rtl/ram_client_if.sv
// Command/response streams plus RAM port signals for ram_client.
// The master modport is the requester/RAM side. The slave modport is the client.
interface ram_client_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [3:0]            req_len;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_cs;
  logic                  ram_we;
  logic                  ram_oe;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready, ram_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_last,
           ram_addr, ram_wdata, ram_cs, ram_we, ram_oe
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready, ram_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_last,
           ram_addr, ram_wdata, ram_cs, ram_we, ram_oe
  );
endinterface

// File: rtl/ram_client.sv
// Single-outstanding RAM port initiator: a write strobes for 1 cycle, and a read takes 3 cycles per beat plus response stall.
// Defining RAM_CLIENT_BURST_EN makes a read perform req_len+1 beats at wrapping addresses.
module ram_client #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  ram_client_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CAP, RESP} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_last;
  logic                  r_ram_cs;
  logic                  r_ram_we;
  logic                  r_ram_oe;
  logic                  w_last;

`ifdef RAM_CLIENT_BURST_EN
  logic [3:0]            r_beats_left;
  assign w_last = (r_beats_left == 4'd0);
`else
  logic                  w_unused_len;
  assign w_unused_len = ^bus.req_len;
  assign w_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
      r_ram_cs    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_oe    <= 1'b0;
`ifdef RAM_CLIENT_BURST_EN
      r_beats_left <= 4'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            r_ram_cs <= 1'b1;
            r_ram_we <= bus.req_we;
            r_ram_oe <= !bus.req_we;
`ifdef RAM_CLIENT_BURST_EN
            r_beats_left <= bus.req_we ? 4'd0 : bus.req_len;
`endif
            r_state  <= bus.req_we ? WR : RD_ISSUE;
          end
        end
        WR: begin
          r_ram_cs <= 1'b0;
          r_ram_we <= 1'b0;
          r_state  <= IDLE;
        end
        RD_ISSUE: begin
          r_state <= RD_CAP;
        end
        RD_CAP: begin
          // RAM output is registered, so data for the RD_ISSUE address is present this cycle.
          r_rsp_data  <= bus.ram_rdata;
          r_rsp_last  <= w_last;
          r_rsp_valid <= 1'b1;
          r_ram_cs    <= 1'b0;
          r_ram_oe    <= 1'b0;
          r_state     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (!w_last) begin
              r_addr   <= r_addr + 1'b1;
              r_ram_cs <= 1'b1;
              r_ram_oe <= 1'b1;
`ifdef RAM_CLIENT_BURST_EN
              r_beats_left <= r_beats_left - 4'd1;
`endif
              r_state  <= RD_ISSUE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_ram_cs    <= 1'b0;
          r_ram_we    <= 1'b0;
          r_ram_oe    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Address and data are forced to 0 whenever the RAM is not selected.
  assign bus.req_ready = (r_state == IDLE) && !rst;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_last  = r_rsp_last;
  assign bus.ram_cs    = r_ram_cs;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_oe    = r_ram_oe;
  assign bus.ram_addr  = r_ram_cs ? r_addr : '0;
  assign bus.ram_wdata = (r_ram_cs && r_ram_we) ? r_wdata : '0;

endmodule

// File: tb/tb_ram_client.sv
// Directed bench for ram_client with a behavioural synchronous RAM behind the port.
module tb_ram_client;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  ram_client_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  ram_client #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_cs && bus.ram_oe && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Waits for req_ready, then presents one command for a single handshake edge.
  // It returns at the negedge of cycle T+1.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [3:0] len);
    int waited = 0;
    while (!bus.req_ready) begin
      step();
      waited++;
      if (waited > 40) begin
        $display("FAIL issue_timeout req_ready=%0b required=1", bus.req_ready);
        $fatal(1, "req_ready never asserted");
      end
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_len   = len;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_last, bus.ram_cs, bus.ram_we, bus.ram_oe} !== 6'b0)
      $display("FAIL reset_outputs got=%b required=000000",
               {bus.req_ready, bus.rsp_valid, bus.rsp_last, bus.ram_cs, bus.ram_we, bus.ram_oe});
    else n_pass++;
    n_checks++;
    if (bus.rsp_data !== 32'h0) $display("FAIL reset_rsp_data got=%h required=0", bus.rsp_data);
    else n_pass++;
    step();
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_release_ready got=%b required=1", bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_write_read();
    issue(1'b1, 8'h10, 32'hDEADBEEF, 4'd0);
    n_checks++;
    if ({bus.ram_cs, bus.ram_we, bus.ram_oe, bus.req_ready} !== 4'b1100)
      $display("FAIL wr_strobe got=%b required=1100", {bus.ram_cs, bus.ram_we, bus.ram_oe, bus.req_ready});
    else n_pass++;
    n_checks++;
    if ({bus.ram_addr, bus.ram_wdata} !== {8'h10, 32'hDEADBEEF})
      $display("FAIL wr_addr_data got=%h_%h required=10_deadbeef", bus.ram_addr, bus.ram_wdata);
    else n_pass++;
    step();
    n_checks++;
    if ({bus.ram_cs, bus.req_ready} !== 2'b01)
      $display("FAIL wr_done got=%b required=01", {bus.ram_cs, bus.req_ready});
    else n_pass++;

    bus.rsp_ready = 1'b1;
    issue(1'b0, 8'h10, 32'h0, 4'd0);
    n_checks++;
    if ({bus.ram_cs, bus.ram_we, bus.ram_oe, bus.ram_addr, bus.rsp_valid} !== {3'b101, 8'h10, 1'b0})
      $display("FAIL rd_issue got=%b_%h_%b required=101_10_0",
               {bus.ram_cs, bus.ram_we, bus.ram_oe}, bus.ram_addr, bus.rsp_valid);
    else n_pass++;
    step();
    n_checks++;
    if ({bus.ram_cs, bus.ram_oe, bus.rsp_valid} !== 3'b110)
      $display("FAIL rd_cap got=%b required=110", {bus.ram_cs, bus.ram_oe, bus.rsp_valid});
    else n_pass++;
    step();
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.ram_cs} !== {2'b11, 32'hDEADBEEF, 1'b0})
      $display("FAIL rd_resp got=v%b l%b d%h cs%b required=v1 l1 ddeadbeef cs0",
               bus.rsp_valid, bus.rsp_last, bus.rsp_data, bus.ram_cs);
    else n_pass++;
    step();
    n_checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01)
      $display("FAIL rd_done got=%b required=01", {bus.rsp_valid, bus.req_ready});
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic ok;
    issue(1'b1, 8'h05, 32'h0505A5A5, 4'd0);
    step();
    bus.rsp_ready = 1'b0;
    issue(1'b0, 8'h05, 32'h0, 4'd0);
    step();
    step();
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(bus.rsp_valid === 1'b1 && bus.rsp_data === 32'h0505A5A5 &&
            bus.req_ready === 1'b0 && bus.ram_cs === 1'b0)) ok = 1'b0;
      step();
    end
    n_checks++;
    if (ok !== 1'b1)
      $display("FAIL bp_hold got=v%b d%h rdy%b cs%b required=v1 d0505a5a5 rdy0 cs0",
               bus.rsp_valid, bus.rsp_data, bus.req_ready, bus.ram_cs);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    step();
    n_checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01)
      $display("FAIL bp_release got=%b required=01", {bus.rsp_valid, bus.req_ready});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] pulses;
    logic       addr_ok;
    pulses  = '0;
    addr_ok = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_len   = 4'd0;
    for (int i = 0; i < 6; i++) begin
      pulses[i] = bus.ram_cs && bus.ram_we;
      if (pulses[i] && bus.ram_addr !== 8'(i / 2)) addr_ok = 1'b0;
      bus.req_addr  = 8'(i / 2);
      bus.req_wdata = 32'h1000 + 32'(i / 2);
      step();
    end
    bus.req_valid = 1'b0;
    n_checks++;
    if (pulses !== 6'b101010) $display("FAIL b2b_pulses got=%b required=101010", pulses);
    else n_pass++;
    n_checks++;
    if (addr_ok !== 1'b1) $display("FAIL b2b_addr got=%b required=1", addr_ok);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    issue(1'b0, 8'h02, 32'h0, 4'd0);
    step();
    step();
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 32'h00001002})
      $display("FAIL b2b_readback got=v%b d%h required=v1 d00001002", bus.rsp_valid, bus.rsp_data);
    else n_pass++;
    step();
  endtask

  task automatic test_burst();
    logic [31:0] got_data [4];
    logic        got_last [4];
    int          beats;
    issue(1'b1, 8'hFE, 32'hAAAA00FE, 4'd0);
    issue(1'b1, 8'hFF, 32'hBBBB00FF, 4'd0);
    issue(1'b1, 8'h00, 32'hCCCC0000, 4'd0);
    bus.rsp_ready = 1'b1;
    issue(1'b0, 8'hFE, 32'h0, 4'd2);
    beats = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.rsp_valid === 1'b1 && beats < 4) begin
        got_data[beats] = bus.rsp_data;
        got_last[beats] = bus.rsp_last;
        beats++;
      end
      step();
    end
`ifdef RAM_CLIENT_BURST_EN
    n_checks++;
    if (beats !== 3) $display("FAIL burst_beats got=%0d required=3", beats);
    else n_pass++;
    n_checks++;
    if (beats >= 3 && {got_data[0], got_data[1], got_data[2]} !== {32'hAAAA00FE, 32'hBBBB00FF, 32'hCCCC0000})
      $display("FAIL burst_data got=%h %h %h required=aaaa00fe bbbb00ff cccc0000",
               got_data[0], got_data[1], got_data[2]);
    else if (beats >= 3) n_pass++;
    else $display("FAIL burst_data got=%0d beats required=3", beats);
    n_checks++;
    if (beats >= 3 && {got_last[0], got_last[1], got_last[2]} !== 3'b001)
      $display("FAIL burst_last got=%b%b%b required=001", got_last[0], got_last[1], got_last[2]);
    else if (beats >= 3) n_pass++;
    else $display("FAIL burst_last got=%0d beats required=3", beats);
`else
    n_checks++;
    if (beats !== 1) $display("FAIL single_beats got=%0d required=1", beats);
    else n_pass++;
    n_checks++;
    if (beats >= 1 && {got_data[0], got_last[0]} !== {32'hAAAA00FE, 1'b1})
      $display("FAIL single_resp got=d%h l%b required=daaaa00fe l1", got_data[0], got_last[0]);
    else if (beats >= 1) n_pass++;
    else $display("FAIL single_resp got=0 beats required=1");
`endif
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL burst_idle got=%b required=1", bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    logic quiet;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 8'h10, 32'h0, 4'd0);
    step();
    n_checks++;
    if (bus.ram_cs !== 1'b1) $display("FAIL rstmid_pre_cs got=%b required=1", bus.ram_cs);
    else n_pass++;
    rst = 1'b1;
    step();
    n_checks++;
    if ({bus.ram_cs, bus.rsp_valid, bus.req_ready} !== 3'b000)
      $display("FAIL rstmid_during got=%b required=000", {bus.ram_cs, bus.rsp_valid, bus.req_ready});
    else n_pass++;
    step();
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if ({bus.rsp_valid, bus.ram_cs, bus.req_ready} !== 3'b001)
      $display("FAIL rstmid_after got=%b required=001", {bus.rsp_valid, bus.ram_cs, bus.req_ready});
    else n_pass++;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.rsp_valid !== 1'b0 || bus.ram_cs !== 1'b0) quiet = 1'b0;
      step();
    end
    n_checks++;
    if (quiet !== 1'b1) $display("FAIL rstmid_no_resp got=%b required=1", quiet);
    else n_pass++;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_checks = 0;
    n_pass   = 0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_len   = '0;
    bus.rsp_ready = 1'b0;
    bus.ram_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    test_reset();
    test_write_read();
    test_backpressure();
    test_back_to_back();
    test_burst();
    test_reset_mid_read();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ram_client.md
# ram_client

Single-port initiator that turns a valid/ready command stream into the chip-select/write-enable/output-enable signalling of one port of the team's synchronous dual-port RAM. It returns read data on a valid/ready response stream. It sits between the FIX parser stages (field store and lookup logic) and a RAM port, so parser logic never handles RAM port timing directly. One command is in flight at a time.

## Interface
- ADDR_WIDTH, 8: RAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32: RAM data width.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  start address.
- req_wdata  in  DATA_WIDTH  write data (writes only).
- req_len  in  4  read burst length minus one; used only with RAM_CLIENT_BURST_EN.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  response accepted when rsp_valid && rsp_ready.
- rsp_data  out  DATA_WIDTH  read data.
- rsp_last  out  1  final beat of the read command.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data (registered inside RAM, gated by cs && oe && !we).
- ram_cs, ram_we, ram_oe  out  1 each  RAM chip select, write enable, output enable.

## Operation
- FSM states: IDLE, WR, RD_ISSUE, RD_CAP, RESP.
- IDLE: req_ready=1, all ram_* outputs 0. On handshake, latch we/addr/wdata/len. Go to WR if req_we, else RD_ISSUE.
- WR: ram_cs=1, ram_we=1, ram_oe=0, ram_addr/ram_wdata = latched values, for exactly one cycle, then IDLE. Writes produce no response.
- RD_ISSUE: ram_cs=1, ram_oe=1, ram_we=0, ram_addr = current address; next state RD_CAP.
- RD_CAP: same RAM signals held; ram_rdata captured into rsp_data at end of cycle; next state RESP.
- RESP: ram_* = 0, rsp_valid=1. rsp_data and rsp_last stay stable until rsp_ready.
  - On handshake with beats remaining: address+1 (wraps 2^ADDR_WIDTH−1 → 0), go to RD_ISSUE.
  - Otherwise go to IDLE.
- req_ready is 0 in every state except IDLE; commands are never accepted mid-operation.
- Reset values: req_ready=0 during rst; after rst deasserts, FSM is in IDLE with req_ready=1. rsp_valid=0, rsp_data=0, rsp_last=0, all ram_* = 0.
- rst asserted mid-command: next edge forces IDLE, drops any pending response, and deasserts ram_cs. A partially completed write is not retried.

## Timing
- Command handshake at cycle T.
- Write: RAM write strobe in T+1; req_ready=1 in T+2. Maximum write rate is one per 2 cycles.
- Read beat: issue in T+1, capture in T+2, rsp_valid from T+3.
- If rsp_ready=1 at T+3, the next burst beat issues at T+4, or req_ready=1 at T+4 after the last beat.
- Each read beat takes 3 cycles plus response backpressure; the RAM is idle while waiting in RESP.

## Configuration
- RAM_CLIENT_BURST_EN defined: a read performs req_len+1 beats (1..16) at consecutive wrapping addresses. rsp_last=1 only on the final beat. req_len is ignored for writes.
- Not defined: req_len is ignored, every read is one beat, and rsp_last=1 on every response.

## Test plan
- Reset: hold rst 3 cycles mid-read -> next cycle rsp_valid=0, ram_cs=0, req_ready=1.
- Write then read: write 0xDEADBEEF to addr 0x10; read 0x10 with rsp_ready=1 -> rsp_data=0xDEADBEEF, rsp_last=1, rsp_valid exactly 3 cycles after the read handshake.
- Backpressure: read addr 0x05 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data held stable, req_ready=0, ram_cs=0 throughout.
- Back-to-back writes: req_valid held 6 cycles with writes to 0x00..0x02 -> ram_cs&&ram_we pulses in alternate cycles, each 1 cycle wide.
- Burst (RAM_CLIENT_BURST_EN): preload 0xFE=A, 0xFF=B, 0x00=C; read addr 0xFE, req_len=2 -> responses A, B, C; rsp_last only on C.
- Burst disabled: same command with req_len=2 -> one response A with rsp_last=1.
